// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: imem read port, downstream control, IF/ID outputs
interface if_stage_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic [31:0]      ifid_pc;
    logic [31:0]      ifid_pc_plus1;
    logic [31:0]      ifid_inst;
    logic             ifid_valid;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_data,
        output imem_addr, ifid_pc, ifid_pc_plus1, ifid_inst, ifid_valid, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_data,
        input  imem_addr, ifid_pc, ifid_pc_plus1, ifid_inst, ifid_valid, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, IF/ID register, redirect/stall, early j resolution
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          EARLY_JUMP = 1'b1,
    parameter int          CNT_W      = 16
) (
    input  logic         CLK,
    input  logic         Reset,
    if_stage_if.master   bus
);
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc_q, ifid_pc_d;
    logic [31:0]      ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic [31:0]      ifid_inst_q, ifid_inst_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus1;
    logic [31:0] jump_target;
    logic        is_j;

    assign pc_plus1    = pc_q + 32'd1;
    assign jump_target = {pc_plus1[31:26], bus.imem_data[25:0]};
    assign is_j        = EARLY_JUMP && (bus.imem_data[31:26] == 6'b000010);

    always_comb begin
        pc_d            = pc_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        if (bus.redirect_valid) begin
            // wrong-path instruction is dropped; IF/ID becomes a bubble
            pc_d         = bus.redirect_target;
            ifid_valid_d = 1'b0;
            ifid_inst_d  = 32'h0;
        end else if (!bus.stall) begin
            ifid_pc_d       = pc_q;
            ifid_pc_plus1_d = pc_plus1;
            ifid_inst_d     = bus.imem_data;
            ifid_valid_d    = 1'b1;
            fetch_count_d   = fetch_count_q + 1'b1;
            pc_d            = is_j ? jump_target : pc_plus1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q            <= RESET_PC;
            ifid_pc_q       <= 32'h0;
            ifid_pc_plus1_q <= 32'h0;
            ifid_inst_q     <= 32'h0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            pc_q            <= pc_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_pc_plus1 = ifid_pc_plus1_q;
    assign bus.ifid_inst     = ifid_inst_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.fetch_count   = fetch_count_q;
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/execute datapath.
- Owns the program counter and drives the instruction-memory read address. Latches the fetched instruction into an IF/ID pipeline register for the decode stage.
- Handles pipeline stall and branch/jump redirect from downstream, plus optional early resolution of J-type jumps.
- PC is a word address: sequential increment is +1, matching the existing instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EARLY_JUMP, 1, when 1, opcode 6'b000010 (j) is resolved in this stage.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- CLK  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register this cycle.
- redirect_valid  in  1  downstream branch/jump taken; load redirect_target.
- redirect_target  in  32  new PC (word address).
- imem_addr  out  32  instruction-memory read address; equals the PC register, combinational.
- imem_data  in  32  instruction at imem_addr, valid in the same cycle (combinational memory).
- ifid_pc  out  32  PC of the latched instruction.
- ifid_pc_plus1  out  32  ifid_pc + 1.
- ifid_inst  out  32  latched instruction; 32'h0 (NOP) when invalid.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_count  out  CNT_W  number of instructions accepted into IF/ID.

Behaviour:
- Reset is asynchronous, active-high, and may assert at any time, including mid-stall or mid-redirect. On reset:
  - pc = RESET_PC
  - ifid_pc = 0, ifid_pc_plus1 = 0, ifid_inst = 0
  - ifid_valid = 0, fetch_count = 0
- Internal pc_plus1 = pc + 1, modulo 2^32; 32'hFFFF_FFFF wraps to 0.
- Jump target jt = {pc_plus1[31:26], imem_data[25:0]}.
- is_j = EARLY_JUMP && imem_data[31:26] == 6'b000010.
- Per rising edge, first matching rule wins:
  1. redirect_valid=1: pc <= redirect_target; ifid_valid <= 0; ifid_inst <= 0; ifid_pc and ifid_pc_plus1 hold; fetch_count holds. The wrong-path instruction at imem_data is discarded. Redirect overrides a simultaneous stall.
  2. stall=1: pc, all IF/ID outputs and fetch_count hold their values.
  3. Otherwise accept: ifid_pc <= pc; ifid_pc_plus1 <= pc_plus1; ifid_inst <= imem_data; ifid_valid <= 1; fetch_count <= fetch_count + 1. fetch_count wraps at 2^CNT_W. Next pc:
     - is_j: pc <= jt. The j instruction itself still enters IF/ID valid; decode must not redirect again for j.
     - else: pc <= pc_plus1.
- Latency: an instruction fetched at PC p appears on ifid_* one edge after it is accepted. Redirect-to-first-valid takes 2 edges: redirect edge (bubble), then accept edge.
- Decode sees exactly one bubble per redirect and zero bubbles per early jump.
- ifid_pc_plus1 is always consistent with ifid_pc, including on wrap.
- No combinational path from stall or redirect_* to imem_addr; imem_addr depends only on the pc register.
- The first edge after reset deasserts performs a normal accept of the instruction at RESET_PC; no extra startup bubble.

Test Plan:
- Reset then 4 free-running edges with imem returning 32'h1000_0000+addr:
  - ifid_pc sequence 0,1,2,3.
  - ifid_inst = 32'h1000_0000..32'h1000_0003.
  - fetch_count = 4, ifid_valid = 1 from the first edge.
- At pc=5, stall=1 for 3 edges:
  - imem_addr stays 5; ifid_* and fetch_count frozen.
  - After release, next edge latches ifid_pc=5.
- At pc=8, assert redirect_valid with target 32'h40, together with stall=1:
  - Next edge: pc=32'h40, ifid_valid=0, ifid_inst=0, fetch_count unchanged.
  - Following edge: ifid_pc=32'h40, ifid_valid=1.
- At pc=32'h0400_0010, imem_data=32'h0800_0123 (j) with EARLY_JUMP=1:
  - ifid_inst=32'h0800_0123, valid=1.
  - pc=32'h0400_0123 next cycle; no bubble.
  - Repeat with EARLY_JUMP=0: pc=32'h0400_0011.
- Force pc to 32'hFFFF_FFFF via redirect, then accept:
  - ifid_pc=32'hFFFF_FFFF, ifid_pc_plus1=0, next pc=0.
  - Also preload fetch_count to 2^CNT_W-1 (CNT_W=4 build): wraps to 0.
- Assert Reset asynchronously between edges during a stall with pc=7:
  - Outputs go to reset values immediately, without a clock edge.
  - imem_addr=RESET_PC.
  - First edge after release fetches RESET_PC.
